// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store access unit between the EX/MEM pipeline register and a 64-bit,
// doubleword-indexed data memory. Byte-addressed requests of 1/2/4/8 bytes are
// turned into doubleword accesses. Sub-doubleword loads are lane-extracted and
// sign/zero-extended. Sub-doubleword stores are done as read-modify-write.
// The upstream pipeline is stalled while an access is in flight.
//
// Ports
//   CLK         system clock, all state updates on the rising edge
//   RST_N       synchronous active-low reset
//   REQ_VALID   request present (sampled only in IDLE)
//   REQ_WRITE   1 = store, 0 = load
//   REQ_SIZE    00 byte, 01 half, 10 word, 11 doubleword
//   REQ_SIGNED  sign-extend loaded data (ignored for stores/doubleword)
//   REQ_ADDR    byte address, little-endian
//   REQ_WDATA   store data, right-justified
//   STALL       high whenever the unit is not IDLE
//   RESP_VALID  one-cycle completion pulse
//   RESP_RDATA  extended load result, held until the next load completes
//   FAULT       one-cycle pulse for a misaligned or out-of-range request
//   MEM_READ    memory read enable
//   MEM_WRITE   memory write enable (gated by RST_N)
//   MEM_ADDR    doubleword index, 0 while IDLE
//   MEM_WDATA   doubleword write data
//   MEM_RDATA   memory read data, combinational read
//
// The data path is written for DATA_W = 64.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    input  logic              REQ_WRITE,
    input  logic [1:0]        REQ_SIZE,
    input  logic              REQ_SIGNED,
    input  logic [63:0]       REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              STALL,
    output logic              RESP_VALID,
    output logic [DATA_W-1:0] RESP_RDATA,
    output logic              FAULT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [63:0]       MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [60:0] MEM_WORDS_IDX = 61'(MEM_WORDS);

    // Right-justified all-ones mask covering one access of the given size.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Mask a right-justified lane to its size and extend to 64 bits.
    // A doubleword never sign-extends, so REQ_SIGNED is a no-op for it.
    function automatic logic [63:0] extend_lane(input logic [63:0] lane,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [63:0] m;
        logic        sb;
        m = size_mask(size);
        case (size)
            2'b00:   sb = lane[7];
            2'b01:   sb = lane[15];
            2'b10:   sb = lane[31];
            default: sb = 1'b0;
        endcase
        if (sgn && sb) begin
            return (lane & m) | ~m;
        end else begin
            return lane & m;
        end
    endfunction

    logic [1:0]        state_r;
    logic              write_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic [2:0]        offset_r;
    logic [60:0]       index_r;
    logic [DATA_W-1:0] wdata_r;      // store data, replaced by the merged word after READ
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              fault_r;

    logic              misalign_s;
    logic              out_of_range_s;
    logic [5:0]        shift_s;
    logic [63:0]       load_data_s;
    logic [63:0]       merge_s;

    // Request legality check on the live request inputs.
    always_comb begin
        misalign_s = 1'b0;
        case (REQ_SIZE)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = REQ_ADDR[0];
            2'b10:   misalign_s = |REQ_ADDR[1:0];
            2'b11:   misalign_s = |REQ_ADDR[2:0];
            default: misalign_s = 1'b1;
        endcase
        out_of_range_s = (REQ_ADDR[63:3] >= MEM_WORDS_IDX);
    end

    // Lane extraction for loads and lane merge for sub-doubleword stores.
    always_comb begin
        shift_s     = {offset_r, 3'b000};
        load_data_s = extend_lane(MEM_RDATA >> shift_s, size_r, signed_r);
        merge_s     = (MEM_RDATA & ~(size_mask(size_r) << shift_s))
                    | ((wdata_r & size_mask(size_r)) << shift_s);
    end

    // Access sequencer: IDLE -> READ [-> WRITE] / IDLE -> WRITE -> IDLE.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            signed_r     <= 1'b0;
            offset_r     <= 3'b000;
            index_r      <= '0;
            wdata_r      <= '0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            fault_r      <= 1'b0;
        end else begin
            resp_valid_r <= 1'b0;
            fault_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        if (misalign_s || out_of_range_s) begin
                            fault_r <= 1'b1;
                        end else begin
                            write_r  <= REQ_WRITE;
                            size_r   <= REQ_SIZE;
                            signed_r <= REQ_SIGNED;
                            offset_r <= REQ_ADDR[2:0];
                            index_r  <= REQ_ADDR[63:3];
                            wdata_r  <= REQ_WDATA;
                            // Full-doubleword stores need no read-back.
                            if (REQ_WRITE && (REQ_SIZE == 2'b11)) begin
                                state_r <= ST_WRITE;
                            end else begin
                                state_r <= ST_READ;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (write_r) begin
                        wdata_r <= merge_s;
                        state_r <= ST_WRITE;
                    end else begin
                        resp_rdata_r <= load_data_s;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign STALL      = (state_r != ST_IDLE);
    assign RESP_VALID = resp_valid_r;
    assign RESP_RDATA = resp_rdata_r;
    assign FAULT      = fault_r;
    assign MEM_READ   = (state_r == ST_READ);
    // Gated by RST_N so a reset landing on a WRITE cycle commits nothing.
    assign MEM_WRITE  = (state_r == ST_WRITE) && RST_N;
    assign MEM_ADDR   = (state_r != ST_IDLE) ? {3'b000, index_r} : 64'h0;
    assign MEM_WDATA  = wdata_r;

endmodule
